// File: rtl/serial_word_rx.sv
// serial_word_rx: start-bit framed serial receiver that delivers one WIDTH-bit
// word per frame through a valid/ready output register.
// Frame: start(0), WIDTH data bits, optional even-parity bit, stop(1).
// Optional feature macro: PARITY_CHECK_EN (adds the parity bit and the PARITY
// state; without it parity_err is tied low).
module serial_word_rx #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
`ifdef PARITY_CHECK_EN
    PARITY = 3'd2,
`endif
    STOP   = 3'd3,
    BREAK  = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shifted_c;
  logic [WIDTH-1:0] out_d;
  logic             out_valid_d;
  logic             frame_err_d;
  logic             overrun_d;
  logic             deliver_c;
`ifdef PARITY_CHECK_EN
  logic             par_bad_q;
  logic             par_bad_d;
  logic             parity_err_d;
`endif

  // Shift register input ordering: first received bit ends up in the MSB or LSB.
  always_comb begin
    shifted_c = shreg_q;
    if (MSB_FIRST != 0) begin
      shifted_c = {shreg_q[WIDTH-2:0], serial_in};
    end else begin
      shifted_c = {serial_in, shreg_q[WIDTH-1:1]};
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    deliver_c   = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    out_d       = out;
    out_valid_d = out_valid & ~out_ready;
`ifdef PARITY_CHECK_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (!serial_in) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end

      DATA: begin
        shreg_d = shifted_c;
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
`ifdef PARITY_CHECK_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef PARITY_CHECK_EN
      PARITY: begin
        // Even parity: data bits XOR parity bit must be zero.
        par_bad_d = (^shreg_q) ^ serial_in;
        state_d   = STOP;
      end
`endif

      STOP: begin
        if (!serial_in) begin
          frame_err_d = 1'b1;
          state_d     = BREAK;
`ifdef PARITY_CHECK_EN
        end else if (par_bad_q) begin
          parity_err_d = 1'b1;
          state_d      = IDLE;
`endif
        end else begin
          deliver_c = 1'b1;
          state_d   = IDLE;
        end
      end

      BREAK: begin
        // Line held low: wait for it to return high before looking for a start bit.
        if (serial_in) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Output register: an unconsumed word is never overwritten.
    if (deliver_c) begin
      if (out_valid && !out_ready) begin
        overrun_d = 1'b1;
      end else begin
        out_d       = shreg_q;
        out_valid_d = 1'b1;
      end
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
    end
  end

`ifdef PARITY_CHECK_EN
  // Parity mismatch flag and its error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad_q  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad_q  <= par_bad_d;
      parity_err <= parity_err_d;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx (WIDTH=4): directed scenarios followed by random
// frames, checked every cycle against a frame-level reference model.
module tb_serial_word_rx;

  localparam int EV_NONE = 0;
  localparam int EV_DLV  = 1;
  localparam int EV_FE   = 2;
  localparam int EV_PE   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic       out_ready;
  logic [3:0] out;
  logic       out_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  logic       serial_in1;
  logic       out_ready1;
  logic [3:0] out1;
  logic       out_valid1;
  logic       frame_err1;
  logic       parity_err1;
  logic       overrun1;

  always #5 clk = ~clk;

  serial_word_rx #(.WIDTH(4), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .out(out),
    .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun)
  );

  serial_word_rx #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in1), .out(out1),
    .out_valid(out_valid1), .out_ready(out_ready1), .frame_err(frame_err1),
    .parity_err(parity_err1), .overrun(overrun1)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] m_out;
  logic       m_valid;
  logic       rdy_rand;
  logic       rdy_val;
  logic       stop_rdy_ovr;
  string      phase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One serial bit; ev is the frame-level outcome decided at this bit.
  task automatic step(input logic b, input int ev, input logic [3:0] w);
    logic rdy;
    logic e_fe;
    logic e_pe;
    logic e_ov;
    rdy = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_val;
    if (ev == EV_DLV && stop_rdy_ovr) rdy = 1'b1;
    serial_in = b;
    out_ready = rdy;
    e_fe = (ev == EV_FE);
    e_pe = (ev == EV_PE);
    e_ov = 1'b0;
    if (ev == EV_DLV) begin
      if (m_valid && !rdy) e_ov = 1'b1;
      else begin
        m_out   = w;
        m_valid = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check({phase, ".out"},        32'(out),        32'(m_out));
    check({phase, ".out_valid"},  32'(out_valid),  32'(m_valid));
    check({phase, ".frame_err"},  32'(frame_err),  32'(e_fe));
    check({phase, ".parity_err"}, 32'(parity_err), 32'(e_pe));
    check({phase, ".overrun"},    32'(overrun),    32'(e_ov));
  endtask

  // Whole frame: start, data MSB first, optional parity, stop.
  task automatic send_frame(input logic [3:0] w, input logic stop, input logic flip);
    logic par;
    par = logic'($countones(w) % 2) ^ flip;
    step(1'b0, EV_NONE, 4'h0);
    for (int i = 3; i >= 0; i--) step(w[i], EV_NONE, 4'h0);
`ifdef PARITY_CHECK_EN
    step(par, EV_NONE, 4'h0);
`else
    if (par === 1'bx) $display("[TB] note: unknown parity");
`endif
    if (!stop)     step(1'b0, EV_FE, 4'h0);
    else if (flip) step(1'b1, EV_PE, 4'h0);
    else           step(1'b1, EV_DLV, w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, EV_NONE, 4'h0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out"},        32'(out),        32'h0);
    check({tag, ".out_valid"},  32'(out_valid),  32'h0);
    check({tag, ".frame_err"},  32'(frame_err),  32'h0);
    check({tag, ".parity_err"}, 32'(parity_err), 32'h0);
    check({tag, ".overrun"},    32'(overrun),    32'h0);
  endtask

  initial begin
    logic       bq[$];
    logic [3:0] w;
    logic       stp;
    logic       flp;

    rst = 1'b1; serial_in = 1'b1; out_ready = 1'b0;
    serial_in1 = 1'b1; out_ready1 = 1'b0;
    rdy_rand = 1'b0; rdy_val = 1'b0; stop_rdy_ovr = 1'b0;
    m_out = 4'h0; m_valid = 1'b0; phase = "reset";

    #2 rst = 1'b0;
    #1;
    check_zero("reset");
    check("reset.lsb_out",   32'(out1),       32'h0);
    check("reset.lsb_valid", 32'(out_valid1), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_held");
    rst = 1'b1;
    idle(2);

    // Basic frame, then consume.
    phase = "basic";
    send_frame(4'hB, 1'b1, 1'b0);
    check("basic.word", 32'(out), 32'hB);
    rdy_val = 1'b1;
    idle(1);
    check("basic.cleared", 32'(out_valid), 32'h0);

    // Bad stop bit, break, then recovery.
    phase = "frame_err";
    send_frame(4'hF, 1'b0, 1'b0);
    repeat (3) step(1'b0, EV_NONE, 4'h0);
    step(1'b1, EV_NONE, 4'h0);
    send_frame(4'h3, 1'b1, 1'b0);
    check("frame_err.recover", 32'(out), 32'h3);
    idle(1);

    // Overrun with consumer stalled, then with consumer ready.
    phase = "overrun";
    rdy_val = 1'b0;
    send_frame(4'hA, 1'b1, 1'b0);
    send_frame(4'h5, 1'b1, 1'b0);
    check("overrun.kept", 32'(out), 32'hA);
    rdy_val = 1'b1;
    idle(1);
    send_frame(4'hA, 1'b1, 1'b0);
    send_frame(4'h5, 1'b1, 1'b0);
    check("ready.new", 32'(out), 32'h5);
    idle(1);

    // Delivery on the same edge as consumption.
    phase = "same_edge";
    rdy_val = 1'b0;
    send_frame(4'hA, 1'b1, 1'b0);
    stop_rdy_ovr = 1'b1;
    send_frame(4'h5, 1'b1, 1'b0);
    stop_rdy_ovr = 1'b0;
    check("same_edge.word",  32'(out),       32'h5);
    check("same_edge.valid", 32'(out_valid), 32'h1);
    rdy_val = 1'b1;
    idle(1);

    // Reset in the middle of a frame while a word is pending.
    phase = "reset_mid";
    rdy_val = 1'b0;
    send_frame(4'h6, 1'b1, 1'b0);
    step(1'b0, EV_NONE, 4'h0);
    step(1'b1, EV_NONE, 4'h0);
    step(1'b0, EV_NONE, 4'h0);
    rst = 1'b0;
    serial_in = 1'b1;
    #1;
    m_out = 4'h0;
    m_valid = 1'b0;
    check_zero("reset_mid");
    @(posedge clk);
    #1;
    check_zero("reset_mid_held");
    rst = 1'b1;
    idle(1);
    send_frame(4'h9, 1'b1, 1'b0);
    check("reset_mid.next", 32'(out), 32'h9);
    rdy_val = 1'b1;
    idle(1);

`ifdef PARITY_CHECK_EN
    phase = "parity";
    send_frame(4'hB, 1'b1, 1'b0);
    check("parity.good", 32'(out), 32'hB);
    idle(1);
    send_frame(4'hB, 1'b1, 1'b1);
    idle(1);
`endif

    // LSB-first instance: data 1,0,0,0 is word 4'h1.
    phase = "lsb_first";
    rdy_val = 1'b0;
    serial_in = 1'b1;
    out_ready = 1'b0;
    bq = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef PARITY_CHECK_EN
    bq.push_back(1'b1);
`endif
    bq.push_back(1'b1);
    foreach (bq[i]) begin
      serial_in1 = bq[i];
      @(posedge clk);
      #1;
    end
    serial_in1 = 1'b1;
    check("lsb.out",       32'(out1),        32'h1);
    check("lsb.valid",     32'(out_valid1),  32'h1);
    check("lsb.frame_err", 32'(frame_err1),  32'h0);
    check("lsb.overrun",   32'(overrun1),    32'h0);

    // Random frames, random consumer, occasional stop/parity errors.
    phase = "random";
    rdy_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      w   = 4'($urandom_range(0, 15));
      stp = ($urandom_range(0, 7) != 0);
`ifdef PARITY_CHECK_EN
      flp = ($urandom_range(0, 7) == 0);
`else
      flp = 1'b0;
`endif
      send_frame(w, stp, flp);
      if (!stp) begin
        repeat ($urandom_range(0, 2)) step(1'b0, EV_NONE, 4'h0);
        step(1'b1, EV_NONE, 4'h0);
      end
      idle(int'($urandom_range(0, 2)));
    end
    rdy_rand = 1'b0;
    rdy_val = 1'b1;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of data bits per frame, minimum 2.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 means the first data bit received is out[WIDTH-1]; 0 means it is out[0].
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port serial_in, input, 1 bit: serial line, idle high, one bit per clk cycle.
REQ-006 SHALL have port out, output, WIDTH bits: last accepted word.
REQ-007 SHALL have port out_valid, output, 1 bit: out holds an unconsumed word.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts out when out_valid=1 and out_ready=1.
REQ-009 SHALL have ports frame_err, parity_err and overrun, outputs, 1 bit each: single-cycle error pulses.

Function
REQ-010 SHALL use a state machine with states IDLE, DATA, PARITY, STOP and BREAK.
REQ-011 IDLE: serial_in=0 sampled -> DATA with bit counter=0; serial_in=1 -> stay in IDLE.
REQ-012 DATA: shift serial_in into a shift register, in the order set by MSB_FIRST; after WIDTH bits -> PARITY if PARITY_CHECK_EN is defined, else -> STOP.
REQ-013 PARITY: sample the even-parity bit (XOR of the data bits and the parity bit must be 0) -> STOP; remember a mismatch.
REQ-014 STOP: serial_in=1 with no parity mismatch -> deliver the word, then -> IDLE.
REQ-015 STOP, serial_in=0: discard the word, pulse frame_err for 1 cycle -> BREAK.
REQ-016 STOP, serial_in=1 with a parity mismatch: discard the word, pulse parity_err for 1 cycle -> IDLE.
REQ-017 BREAK: stay until serial_in=1 is sampled -> IDLE; no start bit is detected while in BREAK.
REQ-018 Latency: out and out_valid SHALL update on the first clk edge after the stop bit is sampled; start bit to out_valid is WIDTH+2 cycles, or WIDTH+3 with parity.
REQ-019 The handshake SHALL clear out_valid on the cycle after out_valid=1 and out_ready=1 unless a new word is delivered on that same edge.
REQ-020 Delivery while out_valid=1 and out_ready=0: keep the old word in out, drop the new word, pulse overrun for 1 cycle.
REQ-021 Delivery on the same edge as consumption (out_valid=1, out_ready=1): load the new word, keep out_valid=1, no overrun.
REQ-022 out SHALL remain stable while out_valid=1 and no delivery occurs.
REQ-023 Back-to-back frames SHALL be supported: a start bit sampled in the cycle after STOP begins a new frame.
REQ-024 frame_err, parity_err and overrun SHALL be registered, never asserted together, and low in all other cycles.

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, bit counter 0, shift register 0, out=0, out_valid=0, frame_err=0, parity_err=0 and overrun=0.
REQ-026 Reset asserted mid-frame SHALL abandon the partial word with no error pulse; reception restarts at the next start bit after rst=1.

Configuration
REQ-027 The macro PARITY_CHECK_EN SHALL control the parity bit.
REQ-028 With PARITY_CHECK_EN defined: frames carry an even-parity bit between the data bits and the stop bit.
REQ-029 With PARITY_CHECK_EN undefined: there is no PARITY state, the frame has no parity bit, and parity_err is tied to 0.

Verification (WIDTH=4, MSB_FIRST=1)
REQ-030 The bench SHALL cover a basic frame: serial_in 0,1,0,1,1 then 1 (no parity) -> out=4'hB, out_valid=1 one cycle after the stop bit; out_ready=1 -> out_valid=0 on the next cycle.
REQ-031 The bench SHALL cover a bad stop bit: serial_in 0,1,1,1,1 then 0 -> frame_err 1-cycle pulse, out_valid stays 0; held low 3 cycles, then 1 then 0,0,0,1,1,1 -> out=4'h3 delivered.
REQ-032 The bench SHALL cover overrun: two back-to-back frames 4'hA then 4'h5 with out_ready=0 -> out=4'hA, overrun pulse at the second delivery; with out_ready=1 held instead -> out=4'h5, no overrun.
REQ-033 The bench SHALL cover reset mid-frame: rst=0 after 2 data bits -> all outputs 0, no error pulse; next full frame 4'h9 -> out=4'h9.
REQ-034 The bench SHALL cover parity (PARITY_CHECK_EN defined): data 1,0,1,1 with parity 1, stop 1 -> out=4'hB; same data with parity 0 -> parity_err pulse, no delivery.
REQ-035 The bench SHALL cover MSB_FIRST=0: data bits 1,0,0,0 -> out=4'h1.
